// File: rtl/alu_share_arbiter.sv
// Shares one external 16-bit ALU between two requesters; operands are registered and the result is captured.
// Latency: accept at edge N, ALU driven in cycle N+1, response valid in N+2; one operation per 3 cycles at best.
// Backpressure: a stalled response holds RESP and both request readies stay low. ALU_ARB_FIXED_PRIO_EN selects fixed priority.
module alu_share_arbiter #(
    parameter int DATA_W = 16,
    parameter int CTRL_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [CTRL_W-1:0] req0_op,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [CTRL_W-1:0] req1_op,

    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DATA_W-1:0] rsp0_result,
    output logic              rsp0_zero,

    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp1_result,
    output logic              rsp1_zero,

    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [CTRL_W-1:0] alu_control,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,

    output logic              busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [DATA_W-1:0]   r_a;
    logic [DATA_W-1:0]   r_b;
    logic [CTRL_W-1:0]   r_op;
    logic                r_gnt_id;
    logic [DATA_W-1:0]   r_result;
    logic                r_zero;

    logic                w_any_vld;
    logic                w_gnt_id;
    logic                w_req0_rdy;
    logic                w_req1_rdy;
    logic                w_rsp0_vld;
    logic                w_rsp1_vld;
    logic                w_accept;
    logic                w_rsp_hs;

`ifdef ALU_ARB_FIXED_PRIO_EN
    always_comb begin
        w_any_vld = req0_valid | req1_valid;
        w_gnt_id  = ~req0_valid;
    end
`else
    logic                r_last_grant;

    // On a tie the requester that was not served last wins.
    always_comb begin
        w_any_vld = req0_valid | req1_valid;
        if (req0_valid && req1_valid)
            w_gnt_id = ~r_last_grant;
        else
            w_gnt_id = ~req0_valid;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_last_grant <= 1'b1;
        else if (w_accept)
            r_last_grant <= w_gnt_id;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_nxt = ST_EXEC;
            ST_EXEC: w_state_nxt = ST_RESP;
            ST_RESP: if (w_rsp_hs) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_req0_rdy = (r_state == ST_IDLE) && w_any_vld && (w_gnt_id == 1'b0);
        w_req1_rdy = (r_state == ST_IDLE) && w_any_vld && (w_gnt_id == 1'b1);
        w_rsp0_vld = (r_state == ST_RESP) && (r_gnt_id == 1'b0);
        w_rsp1_vld = (r_state == ST_RESP) && (r_gnt_id == 1'b1);
        busy       = (r_state != ST_IDLE);
    end

    assign w_accept = (w_req0_rdy & req0_valid) | (w_req1_rdy & req1_valid);
    assign w_rsp_hs = (w_rsp0_vld & rsp0_ready) | (w_rsp1_vld & rsp1_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= '0;
            r_gnt_id <= 1'b0;
        end else if (w_accept) begin
            r_a      <= w_gnt_id ? req1_a  : req0_a;
            r_b      <= w_gnt_id ? req1_b  : req0_b;
            r_op     <= w_gnt_id ? req1_op : req0_op;
            r_gnt_id <= w_gnt_id;
        end
    end

    // The ALU sees only registered operands, so its full cycle ends at this capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result <= '0;
            r_zero   <= 1'b0;
        end else if (r_state == ST_EXEC) begin
            r_result <= alu_result;
            r_zero   <= alu_zero;
        end
    end

    assign req0_ready  = w_req0_rdy;
    assign req1_ready  = w_req1_rdy;
    assign rsp0_valid  = w_rsp0_vld;
    assign rsp1_valid  = w_rsp1_vld;
    assign rsp0_result = r_result;
    assign rsp1_result = r_result;
    assign rsp0_zero   = r_zero;
    assign rsp1_zero   = r_zero;
    assign alu_a       = r_a;
    assign alu_b       = r_b;
    assign alu_control = r_op;

endmodule
